// File: rtl/fp32_pkg.sv
// Shared binary32 constants, exponent helpers and the FSM state encoding
// used by the floating-point multiplier and divider.
package fp32_pkg;

    localparam int BIAS    = 127;
    localparam int EMIN    = -126;
    localparam int EXP_MAX = 255;
    localparam int EXP_W   = 10;

    localparam logic [31:0] QNAN = 32'hFFC00000;
    localparam logic [31:0] INF  = 32'h7F800000;

    localparam logic signed [EXP_W-1:0] EMIN_E = EXP_W'(EMIN);
    localparam logic signed [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SPECIAL,
        S_NORM_IN,
        S_DIV,
        S_NORM_OUT,
        S_ROUND,
        S_PACK
    } fp_state_t;

    // Subnormals sit at EMIN without a hidden bit; normals drop the bias.
    function automatic logic signed [EXP_W-1:0] unbias(input logic [7:0] x);
        logic signed [EXP_W-1:0] e;
        if (x == 8'd0) e = EMIN_E;
        else           e = EXP_W'($signed({2'b00, x}) - BIAS);
        return e;
    endfunction

endpackage

// File: rtl/fdiv_core.sv
// Restoring mantissa divider: one quotient bit per step, remainder shifted
// left after each trial subtraction.
module fdiv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [23:0] i_ma,
    input  logic [23:0] i_mb,
    output logic [26:0] o_q,
    output logic [25:0] o_r
);

    logic [26:0] r_q;
    logic [25:0] r_r;
    logic [23:0] r_mb;

    logic        w_ge;
    logic [25:0] w_rem;

    // NOTE: combinational blocks give every output a value first so no latch is inferred.
    always_comb begin
        w_ge  = 1'b0;
        w_rem = r_r;
        if (r_r >= {2'b00, r_mb}) begin
            w_ge  = 1'b1;
            w_rem = r_r - {2'b00, r_mb};
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q  <= '0;
            r_r  <= '0;
            r_mb <= '0;
        end else if (i_load) begin
            r_q  <= '0;
            r_r  <= {2'b00, i_ma};
            r_mb <= i_mb;
        end else if (i_step) begin
            r_q <= {r_q[25:0], w_ge};
            r_r <= {w_rem[24:0], 1'b0};
        end
    end

    assign o_q = r_q;
    assign o_r = r_r;

endmodule

// File: rtl/fdivider.sv
// Sequential binary32 divider z = a / b: special-case screening, operand
// normalisation, restoring mantissa division, round-to-nearest-even, pack.
module fdivider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z,
    output logic        done,
    output logic        busy,
    output logic        dz
);

    fp_state_t r_state, w_next;

    logic [31:0]             r_a, r_b;
    logic                    r_sa, r_sb, r_sz;
    logic [7:0]              r_xa, r_xb;
    logic [22:0]             r_fa, r_fb;
    logic signed [EXP_W-1:0] r_ea, r_eb, r_ez;
    logic [23:0]             r_ma, r_mb, r_mant;
    logic                    r_g, r_rd, r_s;
    logic                    r_special, r_spec_dz;
    logic [31:0]             r_spec_z;
    logic [4:0]              r_cnt;
    logic [31:0]             r_z;
    logic                    r_done, r_dz;

    logic [26:0] w_q;
    logic [25:0] w_r;
    logic        w_load, w_step;

    assign w_load = (r_state == S_NORM_IN) && r_ma[23] && r_mb[23];
    assign w_step = (r_state == S_DIV);

    fdiv_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_ma   (r_ma),
        .i_mb   (r_mb),
        .o_q    (w_q),
        .o_r    (w_r)
    );

    // Operand classification and the canned result for special cases.
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_is_special, w_spec_dz, w_sign;
    logic [31:0] w_spec_z;

    always_comb begin
        w_a_nan  = (r_xa == EXP_MAX[7:0]) && (r_fa != 23'd0);
        w_b_nan  = (r_xb == EXP_MAX[7:0]) && (r_fb != 23'd0);
        w_a_inf  = (r_xa == EXP_MAX[7:0]) && (r_fa == 23'd0);
        w_b_inf  = (r_xb == EXP_MAX[7:0]) && (r_fb == 23'd0);
        w_a_zero = (r_xa == 8'd0) && (r_fa == 23'd0);
        w_b_zero = (r_xb == 8'd0) && (r_fb == 23'd0);
        w_sign   = r_sa ^ r_sb;
        w_is_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
        w_spec_z  = {w_sign, 31'd0};
        w_spec_dz = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_z = QNAN;
        end else if (w_a_inf) begin
            w_spec_z = {w_sign, INF[30:0]};
        end else if (w_b_zero) begin
            w_spec_z  = {w_sign, INF[30:0]};
            w_spec_dz = 1'b1;
        end
    end

    // Quotient alignment plus denormalising shift for tiny results.
    logic [25:0]             w_ext;
    logic                    w_s;
    logic signed [EXP_W-1:0] w_ez, w_under;
    logic [4:0]              w_sh;
    logic [51:0]             w_wide;

    always_comb begin
        w_under = '0;
        w_sh    = '0;
        w_wide  = '0;
        if (w_q[26]) begin
            w_ext = w_q[26:1];
            w_s   = w_q[0] | (w_r != 26'd0);
            w_ez  = r_ez;
        end else begin
            w_ext = w_q[25:0];
            w_s   = (w_r != 26'd0);
            w_ez  = r_ez - 10'sd1;
        end
        if (w_ez < EMIN_E) begin
            w_under = EMIN_E - w_ez;
            w_sh    = (w_under > 10'sd26) ? 5'd26 : w_under[4:0];
            w_wide  = {w_ext, 26'd0} >> w_sh;
            w_ext   = w_wide[51:26];
            w_s     = w_s | (w_wide[25:0] != 26'd0);
            w_ez    = EMIN_E;
        end
    end

    logic [24:0]             w_sum;
    logic [23:0]             w_rmant;
    logic signed [EXP_W-1:0] w_rez, w_exp_b;
    logic [31:0]             w_pack;

    always_comb begin
        w_sum   = {1'b0, r_mant} + {24'd0, r_g & (r_rd | r_s | r_mant[0])};
        w_rmant = w_sum[23:0];
        w_rez   = r_ez;
        if (w_sum[24]) begin
            w_rmant = w_sum[24:1];
            w_rez   = r_ez + 10'sd1;
        end
        w_exp_b = r_ez + BIAS_E;
        if (r_special)          w_pack = r_spec_z;
        else if (r_ez > BIAS_E) w_pack = {r_sz, INF[30:0]};
        else if (!r_mant[23])   w_pack = {r_sz, 8'd0, r_mant[22:0]};
        else                    w_pack = {r_sz, w_exp_b[7:0], r_mant[22:0]};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_UNPACK;
            S_UNPACK:   w_next = S_SPECIAL;
            S_SPECIAL:  w_next = w_is_special ? S_PACK : S_NORM_IN;
            S_NORM_IN:  if (w_load) w_next = S_DIV;
            S_DIV:      if (r_cnt == 5'd26) w_next = S_NORM_OUT;
            S_NORM_OUT: w_next = S_ROUND;
            S_ROUND:    w_next = S_PACK;
            S_PACK:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a <= '0;  r_b <= '0;
            r_sa <= 1'b0; r_sb <= 1'b0; r_sz <= 1'b0;
            r_xa <= '0; r_xb <= '0; r_fa <= '0; r_fb <= '0;
            r_ea <= '0; r_eb <= '0; r_ez <= '0;
            r_ma <= '0; r_mb <= '0; r_mant <= '0;
            r_g <= 1'b0; r_rd <= 1'b0; r_s <= 1'b0;
            r_special <= 1'b0; r_spec_dz <= 1'b0; r_spec_z <= '0;
            r_cnt <= '0;
            r_z <= '0; r_done <= 1'b0; r_dz <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a <= a;
                    r_b <= b;
                end
                S_UNPACK: begin
                    r_sa <= r_a[31]; r_xa <= r_a[30:23]; r_fa <= r_a[22:0];
                    r_sb <= r_b[31]; r_xb <= r_b[30:23]; r_fb <= r_b[22:0];
                end
                S_SPECIAL: begin
                    r_special <= w_is_special;
                    r_spec_z  <= w_spec_z;
                    r_spec_dz <= w_spec_dz;
                    r_ea <= unbias(r_xa);
                    r_eb <= unbias(r_xb);
                    r_ma <= {r_xa != 8'd0, r_fa};
                    r_mb <= {r_xb != 8'd0, r_fb};
                end
                S_NORM_IN: begin
                    if (!r_ma[23]) begin
                        r_ma <= r_ma << 1;
                        r_ea <= r_ea - 10'sd1;
                    end
                    if (!r_mb[23]) begin
                        r_mb <= r_mb << 1;
                        r_eb <= r_eb - 10'sd1;
                    end
                    if (w_load) begin
                        r_ez  <= r_ea - r_eb;
                        r_sz  <= r_sa ^ r_sb;
                        r_cnt <= '0;
                    end
                end
                S_DIV: r_cnt <= r_cnt + 5'd1;
                S_NORM_OUT: begin
                    r_mant <= w_ext[25:2];
                    r_g    <= w_ext[1];
                    r_rd   <= w_ext[0];
                    r_s    <= w_s;
                    r_ez   <= w_ez;
                end
                S_ROUND: begin
                    r_mant <= w_rmant;
                    r_ez   <= w_rez;
                end
                S_PACK: begin
                    r_z    <= w_pack;
                    r_dz   <= r_special & r_spec_dz;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign z    = r_z;
    assign done = r_done;
    assign dz   = r_dz;
    assign busy = (r_state != S_IDLE);

endmodule

// File: doc/fdivider.md
# fdivider

Sequential IEEE-754 single-precision divider computing z = a / b, the inverse companion to the team's state-stepped floating-point multiplier. It runs a start/done handshake, divides mantissas with a restoring divider (one quotient bit per cycle), rounds to nearest-even, and handles NaN, infinity, zero and subnormal operands. It sits beside the multiplier in the FP datapath and packs its result in the same format.

## Interface
- No parameters. Format fixed at binary32.
- clk    in   1   rising-edge clock
- rst    in   1   synchronous reset, active-low (rst==0 resets on the clock edge)
- start  in   1   request; sampled only in IDLE
- a      in   32  dividend, captured on the accepting edge
- b      in   32  divisor, captured on the accepting edge
- z      out  32  quotient; valid when done=1, held until next done
- done   out  1   one-cycle pulse, result valid
- busy   out  1   high in every state except IDLE
- dz     out  1   divide-by-zero flag (finite non-zero a / zero b); updated with done, held

## Operation
- States: IDLE, UNPACK, SPECIAL, NORM_IN, DIV, NORM_OUT, ROUND, PACK.
- IDLE: start=1 captures a, b and moves to UNPACK. start in other states is ignored; operands are not re-sampled.
- UNPACK: split sign, 8-bit exponent and 23-bit fraction. Use unbiased signed exponents of at least 10 bits.
- SPECIAL: any NaN, 0/0 or inf/inf gives z=0xFFC00000. inf/finite or finite non-zero/0 gives infinity with sign sa^sb; dz=1 only for the /0 case. 0/non-zero or finite/inf gives signed zero. Any special case goes straight to PACK. Otherwise attach the hidden bit; a subnormal gets exponent -126 and no hidden bit.
- NORM_IN: while ma[23]==0 or mb[23]==0, shift that mantissa left 1 and decrement its exponent, one shift per operand per cycle. Exit when both leading bits are 1.
- DIV: ez = ea - eb, sz = sa^sb. Remainder r (26 b) starts at ma. Each of 27 cycles: if r>=mb, set q bit 1 and r -= mb, else q bit 0; then r <<= 1. q[26] weights 2^0.
- NORM_OUT:
  - q[26]=1: mant=q[26:3], g=q[2], rd=q[1], s=q[0]|(r!=0).
  - q[26]=0: mant=q[25:2], g=q[1], rd=q[0], s=(r!=0), ez -= 1.
  - If ez < -126: right-shift {mant,g,rd} by (-126-ez), saturating at 26, OR shifted-out bits into s, set ez=-126.
- ROUND: increment mant if g & (rd|s|mant[0]). On carry out of bit 23, shift right 1 and ez += 1. A subnormal rounding up to 0x800000 becomes normal with no extra action.
- PACK:
  - ez > 127 gives signed infinity.
  - mant[23]==0 gives exponent field 0.
  - Otherwise exponent field = ez+127, fraction = mant[22:0].
  - Register z, pulse done, return to IDLE.

## Timing
- Reset values: z=0, done=0, busy=0, dz=0, state=IDLE, all internal registers 0.
- Reset mid-operation aborts the division; no done pulse follows.
- Accept edge = E0. Normal operands: done is high in the cycle after E33 (latency 33). Add 1 cycle per extra NORM_IN shift beyond the first cycle.
- Special cases: done after E3 (SPECIAL→PACK).
- busy goes high after E0 and low in the same cycle done goes high. start may be asserted during the done cycle and is accepted on the next edge (IDLE).
- Back-to-back throughput: one result per 34 cycles for normal operands.

## Structure
- Package fp32_pkg holds:
  - BIAS=127, EMIN=-126, EXP_MAX=255
  - QNAN=32'hFFC00000, INF=32'h7F800000
  - the state enum, shared with the multiplier.
- One sub-module, fdiv_core: the restoring mantissa iterator (load, step, q/r outputs). The FSM, special cases, normalize, round and pack stay in fdivider.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → z=0x40400000, done exactly 33 cycles after accept, dz=0.
- 0x3F800000 / 0x40400000 (1/3) → z=0x3EAAAAAB (round-to-nearest-even up).
- 0x3F800000 / 0x00000000 → 0x7F800000, dz=1. 0/0 → 0xFFC00000. 0x7F800000 / 0xFF800000 → 0xFFC00000. Each done after 3 cycles.
- 0x7F7FFFFF / 0x3F000000 → 0x7F800000 (overflow). 0x00800000 / 0x40000000 → 0x00400000 (subnormal output).
- 0x00400000 / 0x3F800000 → 0x00400000, latency 34 (one extra NORM_IN shift).
- rst=0 for 1 cycle at cycle 15 of a division → no done, busy=0, z=0; a new start then completes normally. start pulses while busy are ignored.
